// File: rtl/rail_pkg.sv
// Shared types and constants for the digit sequencer and its queue.
package rail_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_MOVE    = 3'd2,
      S_PRESS   = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam logic [3:0] MAX_DIGIT = 4'd9;

   function automatic logic digit_valid(input logic [3:0] d);
      return d <= MAX_DIGIT;
   endfunction

endpackage

// File: rtl/digit_fifo.sv
// Circular queue of 4-bit digits; DEPTH must be a power of two (>= 2).
module digit_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [3:0]               data_in,
   input  logic                     pop,
   output logic [3:0]               head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   logic [3:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] level_next;
   logic          wr;
   logic          rd;

   assign wr   = push && !full;
   assign rd   = pop && (level != '0);
   assign head = mem[rd_ptr];

   always_comb begin
      level_next = level;
      if (wr && !rd)
         level_next = level + 1'b1;
      else if (rd && !wr)
         level_next = level - 1'b1;
   end

   // Storage needs no reset: pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (wr)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
      end else begin
         if (wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd)
            rd_ptr <= rd_ptr + 1'b1;
         level <= level_next;
         full  <= (level_next == LW'(DEPTH));
      end
   end

endmodule

// File: rtl/digit_sequencer.sv
// Pops queued digits and sequences settle, move, press and release for a
// downstream carriage; all outputs are registered.
module digit_sequencer
   import rail_pkg::*;
#(
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned DWELL_CYCLES  = 45_000_000,
   parameter int unsigned GAP_CYCLES    = 1024,
   parameter int unsigned MOVE_TIMEOUT  = 2**30-1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [3:0]               push_digit,
   input  logic                     at_target,
   output logic [3:0]               digit,
   output logic                     load,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     err
);

   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] DWELL_LAST  = 32'(DWELL_CYCLES - 1);
   localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] MOVE_LAST   = 32'(MOVE_TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic [31:0] cnt;
   logic [3:0]  head;
   logic        pop;
   logic        reject;
   logic        accept;
   logic        timeout;

   // Full is the registered flag, so a push at full loses even to a same-cycle pop.
   assign reject = push && (full || !digit_valid(push_digit));
   assign accept = push && !reject;
   assign pop    = (state == S_IDLE) && (level != '0);

   digit_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (accept),
      .data_in (push_digit),
      .pop     (pop),
      .head    (head),
      .level   (level),
      .full    (full)
   );

   always_comb begin
      state_next = state;
      timeout    = 1'b0;
      case (state)
         S_IDLE:
            if (level != '0)
               state_next = S_SETTLE;
         S_SETTLE:
            if (cnt == SETTLE_LAST)
               state_next = S_MOVE;
         S_MOVE:
            if (at_target)
               state_next = S_PRESS;
            else if (cnt == MOVE_LAST) begin
               state_next = S_RELEASE;
               timeout    = 1'b1;
            end
         S_PRESS:
            if (!at_target)
               state_next = S_MOVE;
            else if (cnt == DWELL_LAST)
               state_next = S_RELEASE;
         S_RELEASE:
            if (cnt == GAP_LAST)
               state_next = S_IDLE;
         default:
            state_next = S_IDLE;
      endcase
   end

   // Counter restarts on every state change and saturates rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         digit <= '0;
         load  <= 1'b0;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next != state)
            cnt <= '0;
         else if (cnt != '1)
            cnt <= cnt + 1'b1;
         if (pop)
            digit <= head;
         load <= (state_next == S_PRESS);
         busy <= (state_next != S_IDLE);
         err  <= reject | timeout;
      end
   end

endmodule
